csa_operand_loader: RTL and testbench

Upstream feeder for the six-operand carry-save adder. It accepts a serial stream of W-bit operands over a valid/ready handshake and packs each group of six into parallel registers a..f. It then presents the group to the adder with an out_valid/out_ready handshake. It also tracks the adder pipeline latency and emits res_valid on the cycle the adder's result for that group is valid.

---
 rtl/csa_operand_loader_pkg.sv | 27 ++
 rtl/csa_valid_delay.sv | 37 +++
 rtl/csa_operand_loader.sv | 142 ++++++++++++++
 tb/tb_csa_operand_loader.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/csa_operand_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : csa_operand_loader_pkg
//  Description : Shared constants and state encoding for the six-operand
//                carry-save adder operand loader.
//  Revision    : 1.0 - initial release
// ============================================================================
package csa_operand_loader_pkg;

  // Operands per adder group (slots a..f).
  localparam int NUM_OPS = 6;

  // Default adder latency, sampled operands to result valid.
  localparam int CSA_LAT_DEFAULT = 3;

  // Width of the fill counter (holds 0..NUM_OPS-1).
  localparam int CNT_W = 3;

  // FILL : the fill bank can take an operand.
  // STALL: five operands held while an untaken group blocks the output.
  typedef enum logic [0:0] {
    ST_FILL  = 1'b0,
    ST_STALL = 1'b1
  } state_t;

endpackage : csa_operand_loader_pkg
`default_nettype wire

// File: rtl/csa_valid_delay.sv
`default_nettype none
// ============================================================================
//  Module      : csa_valid_delay
//  Description : DEPTH-stage single-bit shift register. Tracks the adder
//                pipeline so that dout marks the cycle the adder result for a
//                transferred group is valid.
//  Ports       : clk   - clock
//                rst_n - asynchronous active-low reset, clears all stages
//                din   - transfer strobe entering the pipe
//                dout  - last stage of the pipe
//  Revision    : 1.0 - initial release
// ============================================================================
module csa_valid_delay #(
  parameter int DEPTH = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] r_pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pipe <= '0;
    end else begin
      // The concatenation is one bit wider than the pipe; the cast drops the
      // oldest stage. This form also holds for DEPTH == 1.
      r_pipe <= DEPTH'({r_pipe, din});
    end
  end

  assign dout = r_pipe[DEPTH-1];

endmodule : csa_valid_delay
`default_nettype wire

// File: rtl/csa_operand_loader.sv
`default_nettype none
// ============================================================================
//  Module      : csa_operand_loader
//  Description : Packs a serial W-bit operand stream into groups of six and
//                presents each group on a..f to a six-operand carry-save
//                adder. Tracks the adder latency and flags res_valid when the
//                adder result for a transferred group is valid.
//  Ports       : clk        - clock, rising edge
//                reset      - asynchronous active-low reset
//                in_valid   - in_data carries an operand
//                in_data    - operand value
//                in_ready   - loader can take an operand this cycle
//                abort      - discard the partially filled group
//                a..f       - operand group to the adder
//                out_valid  - a..f hold a complete, untaken group
//                out_ready  - adder accepts the group this cycle
//                res_valid  - adder result belongs to a transferred group
//                fill_count - operands held in the fill bank (0..5)
//  Revision    : 1.0 - initial release
// ============================================================================
module csa_operand_loader
  import csa_operand_loader_pkg::*;
#(
  parameter int W       = 4,
  parameter int CSA_LAT = CSA_LAT_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [W-1:0]     in_data,
  output logic             in_ready,
  input  logic             abort,
  output logic [W-1:0]     a,
  output logic [W-1:0]     b,
  output logic [W-1:0]     c,
  output logic [W-1:0]     d,
  output logic [W-1:0]     e,
  output logic [W-1:0]     f,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             res_valid,
  output logic [CNT_W-1:0] fill_count
);

  localparam logic [CNT_W-1:0] C_LAST_SLOT = CNT_W'(NUM_OPS - 1);

  // Fill bank: first five operands of the group being assembled. The sixth
  // operand goes straight from in_data into the output bank.
  logic [W-1:0]     r_slot [0:NUM_OPS-2];
  logic [W-1:0]     r_ops  [0:NUM_OPS-1];
  logic [CNT_W-1:0] r_count;
  logic             r_out_valid;
  state_t           r_state;

  logic             w_accept;
  logic             w_xfer;
  logic             w_last;
  logic             w_issue;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_ov_nxt;

  // STALL is registered as (count==5 && out_valid), so this equals
  // count<5 || !out_valid || out_ready, letting a sixth beat complete on the
  // same edge as an output transfer.
  assign in_ready = reset && ((r_state == ST_FILL) || out_ready);

  assign w_accept = in_valid && in_ready;
  assign w_xfer   = r_out_valid && out_ready;
  assign w_last   = (r_count == C_LAST_SLOT);

  always_comb begin
    w_cnt_nxt = r_count;
    w_ov_nxt  = r_out_valid;
    w_issue   = 1'b0;
    if (w_xfer) begin
      w_ov_nxt = 1'b0;
    end
    // abort wins over any beat in the same cycle, including a sixth one.
    if (abort) begin
      w_cnt_nxt = '0;
    end else if (w_accept) begin
      if (w_last) begin
        w_cnt_nxt = '0;
        w_ov_nxt  = 1'b1;
        w_issue   = 1'b1;
      end else begin
        w_cnt_nxt = r_count + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_state     <= ST_FILL;
      for (int i = 0; i < NUM_OPS - 1; i++) begin
        r_slot[i] <= '0;
      end
      for (int i = 0; i < NUM_OPS; i++) begin
        r_ops[i] <= '0;
      end
    end else begin
      r_count     <= w_cnt_nxt;
      r_out_valid <= w_ov_nxt;
      r_state     <= ((w_cnt_nxt == C_LAST_SLOT) && w_ov_nxt) ? ST_STALL : ST_FILL;

      if (w_accept && !abort && !w_last) begin
        r_slot[r_count] <= in_data;
      end

      // An issue only happens when the output bank is free or being
      // transferred this cycle, so held groups are never overwritten.
      if (w_issue) begin
        for (int i = 0; i < NUM_OPS - 1; i++) begin
          r_ops[i] <= r_slot[i];
        end
        r_ops[NUM_OPS-1] <= in_data;
      end
    end
  end

  csa_valid_delay #(
    .DEPTH (CSA_LAT)
  ) u_valid_delay (
    .clk   (clk),
    .rst_n (reset),
    .din   (w_xfer),
    .dout  (res_valid)
  );

  assign a          = r_ops[0];
  assign b          = r_ops[1];
  assign c          = r_ops[2];
  assign d          = r_ops[3];
  assign e          = r_ops[4];
  assign f          = r_ops[5];
  assign out_valid  = r_out_valid;
  assign fill_count = r_count;

endmodule : csa_operand_loader
`default_nettype wire

// File: tb/tb_csa_operand_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_csa_operand_loader
//  Description : Self-checking bench for csa_operand_loader. Accepted beats
//                feed a reference model that assembles groups of six into an
//                expected-group queue; a monitor checks every cycle and pops
//                a group on each output transfer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_csa_operand_loader;

  localparam int W   = 4;
  localparam int LAT = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         abort = 1'b0;
  logic         out_ready = 1'b0;
  logic         in_ready;
  logic [W-1:0] a, b, c, d, e, f;
  logic         out_valid;
  logic         res_valid;
  logic [2:0]   fill_count;

  csa_operand_loader #(
    .W       (W),
    .CSA_LAT (LAT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .abort      (abort),
    .a          (a),
    .b          (b),
    .c          (c),
    .d          (d),
    .e          (e),
    .f          (f),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .res_valid  (res_valid),
    .fill_count (fill_count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit rand_or  = 1'b0;

  logic [W-1:0]   partial[$];   // operands of the group being assembled
  logic [6*W-1:0] exp_q[$];     // issued groups, a in the top bits
  int             res_q[$];     // cycles on which res_valid must be high
  logic [6*W-1:0] last_grp = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  function automatic int grp_sum(input logic [6*W-1:0] g);
    int s = 0;
    for (int i = 0; i < 6; i++) s += int'(g[i*W +: W]);
    return s;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [6*W-1:0] grp;
    bit             exp_res;
    bit             exp_rdy;
    int             dut_sum;
    cyc++;
    grp = {a, b, c, d, e, f};
    if (!reset) begin
      chk("rst_in_ready",  32'(in_ready),   32'd0);
      chk("rst_out_valid", 32'(out_valid),  32'd0);
      chk("rst_res_valid", 32'(res_valid),  32'd0);
      chk("rst_fill",      32'(fill_count), 32'd0);
      chk("rst_ops",       32'(grp),        32'd0);
      res_q.delete();
      last_grp = '0;
    end else begin
      chk("fill_count", 32'(fill_count), 32'(partial.size()));
      chk("out_valid",  32'(out_valid),  32'(exp_q.size() != 0));
      exp_rdy = !((partial.size() == 5) && (exp_q.size() != 0) && !out_ready);
      chk("in_ready", 32'(in_ready), 32'(exp_rdy));
      while (res_q.size() > 0 && res_q[0] < cyc) void'(res_q.pop_front());
      exp_res = (res_q.size() > 0) && (res_q[0] == cyc);
      if (exp_res) void'(res_q.pop_front());
      chk("res_valid", 32'(res_valid), 32'(exp_res));
      if (out_valid && exp_q.size() != 0)
        chk("group", 32'(grp), 32'(exp_q[0]));
      else if (!out_valid)
        chk("held_ops", 32'(grp), 32'(last_grp));
      if (out_valid && out_ready && exp_q.size() != 0) begin
        dut_sum = int'(a) + int'(b) + int'(c) + int'(d) + int'(e) + int'(f);
        chk("adder_sum", 32'(dut_sum), 32'(grp_sum(exp_q[0])));
        last_grp = exp_q.pop_front();
        res_q.push_back(cyc + LAT);
      end
    end
  end

  // Random out_ready during the random phase.
  always @(posedge clk) begin
    if (rand_or) begin
      #1;
      out_ready = ($urandom_range(0, 99) < 60);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_accept(input logic [W-1:0] v);
    partial.push_back(v);
    if (partial.size() == 6) begin
      exp_q.push_back({partial[0], partial[1], partial[2], partial[3], partial[4], partial[5]});
      partial.delete();
    end
  endtask

  // Called at 1 time unit after a rising edge; returns likewise, with
  // in_valid still asserted so back-to-back calls stream without gaps.
  task automatic send(input logic [W-1:0] v);
    in_valid = 1'b1;
    in_data  = v;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #2;
      if (in_ready && reset) begin
        model_accept(v);
        tick();
        return;
      end
      tick();
    end
    checks++;
    failures++;
    $display("FAIL send_timeout cyc=%0d actual=in_ready_low required=accept", cyc);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic do_abort(input bit with_beat, input logic [W-1:0] v);
    abort    = 1'b1;
    in_valid = with_beat;
    in_data  = v;
    @(negedge clk);
    #2;
    partial.delete();
    tick();
    abort    = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    int r;
    repeat (3) tick();
    reset = 1'b1;
    tick();

    // Basic group, result 52.
    out_ready = 1'b1;
    send(4'd13); send(4'd10); send(4'd5); send(4'd11); send(4'd12); send(4'd1);
    idle(6);

    // Stall with the output blocked, then coincident transfer and issue.
    out_ready = 1'b0;
    send(4'd13);
    for (int i = 0; i < 5; i++) send(4'd15);
    for (int i = 1; i <= 5; i++) send(4'(i));
    idle(3);
    out_ready = 1'b1;
    send(4'd6);
    idle(6);

    // Continuous stream 1..12.
    for (int i = 1; i <= 12; i++) send(4'(i));
    idle(6);

    // Abort after three beats, then a group of 2s.
    send(4'd9); send(4'd9); send(4'd9);
    do_abort(1'b0, 4'd0);
    for (int i = 0; i < 6; i++) send(4'd2);
    idle(6);

    // Reset one cycle after a transfer, while the result is in flight.
    for (int i = 1; i <= 6; i++) send(4'(i + 3));
    in_valid = 1'b0;
    tick();
    #2;
    reset = 1'b0;
    partial.delete();
    exp_q.delete();
    repeat (2) tick();
    reset = 1'b1;
    idle(6);

    // Abort coinciding with the sixth beat.
    for (int i = 1; i <= 5; i++) send(4'(i));
    do_abort(1'b1, 4'd7);
    idle(4);

    // Random traffic.
    rand_or = 1'b1;
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 99);
      if (r < 4)       do_abort(1'($urandom_range(0, 1)), 4'($urandom));
      else if (r < 20) idle($urandom_range(1, 3));
      else             send(4'($urandom));
    end
    rand_or = 1'b0;
    tick();
    out_ready = 1'b1;
    idle(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_csa_operand_loader
`default_nettype wire
